sram_arbiter: RTL and testbench

// Shares the single off-chip SRAM (18-bit address, 16-bit data, active-low strobes) between two requesters:

---
 rtl/sram_arbiter.sv | 146 ++++++++++++++
 tb/tb_sram_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one asynchronous SRAM between a host port (A) and a UART port (B).
// A clocked FSM owns all strobe timing; every ram_* output comes straight from a flop.
module sram_arbiter #(
  parameter int WR_SETUP = 1,
  parameter int WR_PULSE = 2,
  parameter int WR_HOLD  = 1,
  parameter int RD_WAIT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [17:0] a_addr,
  input  logic [15:0] a_wdata,
  output logic        a_ack,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [17:0] b_addr,
  input  logic [15:0] b_wdata,
  output logic        b_ack,
  output logic [15:0] b_rdata,
  output logic        busy,
  output logic [17:0] ram_addr,
  inout  tri   [15:0] ram_data,
  output logic        ram_en,
  output logic        ram_oe,
  output logic        ram_we
);

  localparam int MAX_AB  = (WR_SETUP > WR_PULSE) ? WR_SETUP : WR_PULSE;
  localparam int MAX_CD  = (WR_HOLD > RD_WAIT) ? WR_HOLD : RD_WAIT;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  // The counter only ever holds (duration - 1), so MAX_CYC-1 sets the width.
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] WS_LOAD = CNT_W'(WR_SETUP - 1);
  localparam logic [CNT_W-1:0] WP_LOAD = CNT_W'(WR_PULSE - 1);
  localparam logic [CNT_W-1:0] WH_LOAD = CNT_W'(WR_HOLD - 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);

  typedef enum logic [2:0] {IDLE, WS, WP, WH, RD, DONE} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              last_b;
  logic              gnt_b;
  logic              any_req, sel_b, sel_we, accept;
  logic              drive, drive_nx;
  logic              en_nx, oe_nx, we_nx, a_ack_nx, b_ack_nx;
  logic              rd_cap;
  logic [15:0]       wdata_q;

  // On a tie the port that did not win last time is served.
  always_comb begin
    any_req = a_req | b_req;
    sel_b   = b_req & (~a_req | ~last_b);
    sel_we  = sel_b ? b_we : a_we;
    accept  = (state == IDLE) & any_req;
    rd_cap  = (state == RD) & (cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = sel_we ? WS : RD;
      WS:      if (cnt == '0) state_nx = WP;
      WP:      if (cnt == '0) state_nx = WH;
      WH:      if (cnt == '0) state_nx = DONE;
      RD:      if (cnt == '0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    cnt_nx = (cnt == '0) ? '0 : cnt - CNT_W'(1);
    if (state_nx != state) begin
      case (state_nx)
        WS:      cnt_nx = WS_LOAD;
        WP:      cnt_nx = WP_LOAD;
        WH:      cnt_nx = WH_LOAD;
        RD:      cnt_nx = RD_LOAD;
        default: cnt_nx = '0;
      endcase
    end
  end

  // Strobe values are decoded from the next state and registered below.
  always_comb begin
    drive_nx = (state_nx == WS) | (state_nx == WP) | (state_nx == WH);
    en_nx    = ~(drive_nx | (state_nx == RD));
    oe_nx    = (state_nx != RD);
    we_nx    = (state_nx != WP);
    a_ack_nx = (state_nx == DONE) & ~gnt_b;
    b_ack_nx = (state_nx == DONE) & gnt_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_en   <= 1'b1;
      ram_oe   <= 1'b1;
      ram_we   <= 1'b1;
      drive    <= 1'b0;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      last_b   <= 1'b1;
      gnt_b    <= 1'b0;
      ram_addr <= '0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      ram_en <= en_nx;
      ram_oe <= oe_nx;
      ram_we <= we_nx;
      drive  <= drive_nx;
      a_ack  <= a_ack_nx;
      b_ack  <= b_ack_nx;
      if (accept) begin
        gnt_b    <= sel_b;
        last_b   <= sel_b;
        ram_addr <= sel_b ? b_addr : a_addr;
      end
      if (rd_cap) begin
        if (gnt_b) b_rdata <= ram_data;
        else       a_rdata <= ram_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) wdata_q <= sel_b ? b_wdata : a_wdata;
  end

  assign busy     = (state != IDLE);
  assign ram_data = drive ? wdata_q : 16'bz;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: table of single transactions, then arbitration,
// back-to-back, reset-during-write and random traffic sequences against a small SRAM model.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [17:0] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_ack, b_ack, busy, ram_en, ram_oe, ram_we;
  logic [15:0] a_rdata, b_rdata;
  logic [17:0] ram_addr;
  tri   [15:0] ram_data;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  logic [15:0] sram    [0:255];
  logic [15:0] ref_mem [0:255];

  sram_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .busy(busy), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_en(ram_en), .ram_oe(ram_oe), .ram_we(ram_we)
  );

  always #5 clk = ~clk;

  // SRAM model: drives the bus while selected with oe low, stores while we low.
  assign ram_data = (!ram_en && !ram_oe) ? sram[ram_addr[7:0]] : 16'bz;
  always @(posedge clk) begin
    if (!ram_en && !ram_we) sram[ram_addr[7:0]] <= ram_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Whenever oe is low, the bus must carry only the SRAM's value and we must be high.
  always @(negedge clk) begin
    if (mon_en && !rst && !ram_oe) begin
      n_tests++;
      if (!ram_we || ram_data !== sram[ram_addr[7:0]]) begin
        n_fail++;
        $display("FAIL bus_contention: we=%0b data=%0h sram=%0h", ram_we, ram_data, sram[ram_addr[7:0]]);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Issue one transaction on one port (0=A, 1=B); returns edges-to-ack and observed strobe stats.
  task automatic run_txn(input bit port, input bit we, input logic [17:0] addr, input logic [15:0] wd,
                         output int lat, output int we_lo, output int oe_lo,
                         output int bus_bad, output int wrong_ack);
    lat = -1; we_lo = 0; oe_lo = 0; bus_bad = 0; wrong_ack = 0;
    if (port) begin b_we = we; b_addr = addr; b_wdata = wd; b_req = 1'b1; end
    else      begin a_we = we; a_addr = addr; a_wdata = wd; a_req = 1'b1; end
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (!ram_we) we_lo++;
      if (!ram_oe) oe_lo++;
      if (!ram_en && ram_addr != addr) bus_bad++;
      if (we && !ram_en && ram_data !== wd) bus_bad++;
      if (port ? a_ack : b_ack) wrong_ack++;
      if (port ? b_ack : a_ack) begin lat = c; break; end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    if (we && lat > 0) ref_mem[addr[7:0]] = wd;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [17:0] addr;
    logic [15:0] wd;
    int          exp_lat;
    int          exp_we_lo;
    int          exp_oe_lo;
    logic [15:0] exp_a_rd;
    logic [15:0] exp_b_rd;
  } vec_t;

  vec_t vecs [0:8];

  initial begin
    int lat, we_lo, oe_lo, bus_bad, wrong_ack;
    int got, cyc, prev, idle_cnt, acks, bad_b;
    logic [15:0] pa, pb, ea, eb;

    vecs[0] = '{0, 1, 18'h00012, 16'hBEEF, 5, 2, 0, 16'h0000, 16'h0000};
    vecs[1] = '{1, 0, 18'h00012, 16'h0000, 3, 0, 2, 16'h0000, 16'hBEEF};
    vecs[2] = '{0, 0, 18'h00012, 16'h0000, 3, 0, 2, 16'hBEEF, 16'hBEEF};
    vecs[3] = '{1, 1, 18'h00034, 16'h1234, 5, 2, 0, 16'hBEEF, 16'hBEEF};
    vecs[4] = '{0, 0, 18'h00034, 16'h0000, 3, 0, 2, 16'h1234, 16'hBEEF};
    vecs[5] = '{1, 1, 18'h3FFFF, 16'hFFFF, 5, 2, 0, 16'h1234, 16'hBEEF};
    vecs[6] = '{1, 0, 18'h3FFFF, 16'h0000, 3, 0, 2, 16'h1234, 16'hFFFF};
    vecs[7] = '{0, 1, 18'h00000, 16'h0000, 5, 2, 0, 16'h1234, 16'hFFFF};
    vecs[8] = '{1, 0, 18'h00034, 16'h0000, 3, 0, 2, 16'h1234, 16'h1234};

    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    do_reset();

    check("rst_ram_en", ram_en, 1);
    check("rst_ram_oe", ram_oe, 1);
    check("rst_ram_we", ram_we, 1);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_a_ack", a_ack, 0);
    check("rst_b_ack", b_ack, 0);
    check("rst_a_rdata", a_rdata, 0);
    check("rst_b_rdata", b_rdata, 0);
    check("rst_busy", busy, 0);
    mon_en = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wd, lat, we_lo, oe_lo, bus_bad, wrong_ack);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_we_low", i), we_lo, vecs[i].exp_we_lo);
      check($sformatf("v%0d_oe_low", i), oe_lo, vecs[i].exp_oe_lo);
      check($sformatf("v%0d_bus", i), bus_bad, 0);
      check($sformatf("v%0d_other_ack", i), wrong_ack, 0);
      check($sformatf("v%0d_a_rdata", i), a_rdata, vecs[i].exp_a_rd);
      check($sformatf("v%0d_b_rdata", i), b_rdata, vecs[i].exp_b_rd);
    end

    // Both ports requesting continuously from reset: A,B,A,B with reads every 4 cycles.
    do_reset();
    a_we = 0; a_addr = 18'h00012; b_we = 0; b_addr = 18'h00034;
    a_req = 1; b_req = 1;
    cyc = 0; prev = 0;
    for (int k = 0; k < 4; k++) begin
      got = -1;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk); #1;
        cyc++;
        if (a_ack && b_ack) got = 2;
        else if (a_ack)     got = 0;
        else if (b_ack)     got = 1;
        if (got >= 0) break;
      end
      check($sformatf("alt%0d_port", k), got, k % 2);
      if (k > 0) check($sformatf("alt%0d_gap", k), cyc - prev, 4);
      prev = cyc;
    end
    a_req = 0; b_req = 0;
    repeat (2) @(posedge clk);
    #1;
    check("alt_a_rdata", a_rdata, 16'hBEEF);
    check("alt_b_rdata", b_rdata, 16'h1234);

    // Port A back-to-back writes with B idle: one IDLE cycle between each.
    a_we = 1; a_addr = 18'h00040; a_wdata = 16'hA5A5; a_req = 1;
    cyc = 0; prev = 0; idle_cnt = 0; acks = 0; bad_b = 0;
    for (int c = 0; c < 40 && acks < 3; c++) begin
      @(posedge clk); #1;
      cyc++;
      if (!busy) idle_cnt++;
      if (b_ack) bad_b++;
      if (a_ack) begin
        if (acks > 0) begin
          check($sformatf("b2b%0d_idle", acks), idle_cnt, 1);
          check($sformatf("b2b%0d_gap", acks), cyc - prev, 6);
        end
        idle_cnt = 0;
        prev = cyc;
        acks++;
      end
    end
    a_req = 0;
    check("b2b_acks", acks, 3);
    check("b2b_b_ack", bad_b, 0);
    repeat (2) @(posedge clk);
    #1;

    // Reset during the write pulse aborts at once, clears rdata and the grant pointer.
    a_we = 1; a_addr = 18'h00055; a_wdata = 16'h7777; a_req = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("wp_we_low", ram_we, 0);
    rst = 1; a_req = 0;
    @(posedge clk); #1;
    check("abort_ram_we", ram_we, 1);
    check("abort_ram_en", ram_en, 1);
    check("abort_ram_oe", ram_oe, 1);
    check("abort_busy", busy, 0);
    check("abort_a_ack", a_ack, 0);
    check("abort_a_rdata", a_rdata, 0);
    rst = 0;
    acks = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (a_ack || b_ack) acks++;
    end
    check("abort_no_ack", acks, 0);
    a_we = 0; a_addr = 18'h00012; b_we = 0; b_addr = 18'h00034;
    a_req = 1; b_req = 1;
    got = -1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (a_ack)      got = 0;
      else if (b_ack) got = 1;
      if (got >= 0) break;
    end
    a_req = 0; b_req = 0;
    check("abort_first_grant", got, 0);
    repeat (2) @(posedge clk);
    #1;

    // Random traffic over a 16-word window, preceded by a fill so every read is defined.
    for (int i = 0; i < 16; i++) begin
      run_txn(i[0], 1'b1, 18'(i), 16'($urandom), lat, we_lo, oe_lo, bus_bad, wrong_ack);
      check($sformatf("fill%0d_latency", i), lat, 5);
    end
    for (int i = 0; i < 30; i++) begin
      bit          p, w;
      logic [17:0] ad;
      logic [15:0] wd;
      p  = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      ad = 18'($urandom_range(0, 15));
      wd = 16'($urandom);
      pa = a_rdata;
      pb = b_rdata;
      ea = (!w && !p) ? ref_mem[ad[7:0]] : pa;
      eb = (!w &&  p) ? ref_mem[ad[7:0]] : pb;
      run_txn(p, w, ad, wd, lat, we_lo, oe_lo, bus_bad, wrong_ack);
      check($sformatf("rnd%0d_latency", i), lat, w ? 5 : 3);
      check($sformatf("rnd%0d_bus", i), bus_bad + wrong_ack, 0);
      check($sformatf("rnd%0d_a_rdata", i), a_rdata, ea);
      check($sformatf("rnd%0d_b_rdata", i), b_rdata, eb);
    end

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
